// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction prefetch queue.
package fetch_pkg;

  // IF/ID latch control encodings.
  localparam logic [1:0] CTR_ADV   = 2'b00;
  localparam logic [1:0] CTR_STALL = 2'b01;
  localparam logic [1:0] CTR_FLUSH = 2'b10;

  localparam logic [31:0] NOP_INSN = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // One buffered fetch: the address of the following instruction plus the word.
  typedef struct packed {
    logic [31:0] n_pc;
    logic [31:0] isn;
  } fq_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bus bundle between the prefetch queue, instruction memory and the IF/ID latch.
// slave: the fetch_queue side. master: memory / pipeline side.
interface fetch_queue_if;

  logic [1:0]  ctr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] isn;
  logic [31:0] n_pc;
  logic        out_valid;
  logic        busy;

  modport slave (
    input  ctr, redirect, redirect_pc, imem_ack, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, isn, n_pc, out_valid, busy
  );

  modport master (
    output ctr, redirect, redirect_pc, imem_ack, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, isn, n_pc, out_valid, busy
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used as the prefetch buffer. Clear has priority over push/pop;
// pointers wrap naturally because DEPTH is a power of two.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Next pointer and occupancy; a pop on an empty FIFO is ignored.
  always_comb begin
    do_push  = push_i & ~clear_i;
    do_pop   = pop_i & ~clear_i & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer/occupancy registers; overflow means the credit logic upstream is broken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      assert (clear_i || !(push_i && !pop_i && count_q == CW'(DEPTH)));
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between instruction memory and the IF/ID latch.
// Keeps the fetch PC, issues in-order requests under a credit limit, buffers
// returned words with their next-PC, and drops in-flight responses on redirect.
// Optional macro FETCH_QUEUE_BYPASS_EN: a kept response reaching an empty
// queue is presented on the outputs in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  fetch_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  // Outstanding/discard can exceed DEPTH after back-to-back redirects with a
  // slow memory, so they get generous headroom.
  localparam int OW = 16;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   last_npc_q, last_npc_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_push, fifo_pop;
  fq_entry_t     fifo_head;
  fq_entry_t     resp_entry;
  fq_entry_t     head;

  logic          redir;
  logic [31:0]   redir_pc;
  logic [OW-1:0] in_flight;
  logic          req;
  logic          fire;
  logic          keep;
  logic          byp;
  logic          head_valid;
  logic          pop;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fq_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (redir),
    .din_i   (resp_entry),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // Request credit, response keep/drop, head selection and pop decision.
  always_comb begin
    redir = bus.redirect | (bus.ctr == CTR_FLUSH);
    // A plain flush refetches the first instruction not yet taken by IF/ID.
    redir_pc = bus.redirect ? word_align(bus.redirect_pc) : last_npc_q;

    in_flight = OW'(fifo_count) + outstanding_q - discard_q;
    req       = ~redir & (in_flight < OW'(DEPTH));
    fire      = req & bus.imem_ack;

    // A response in the redirect cycle belongs to the old stream.
    keep = bus.imem_rvalid & (discard_q == '0) & ~redir;

    resp_entry.n_pc = resp_pc_q + PC_STEP;
    resp_entry.isn  = bus.imem_rdata;

`ifdef FETCH_QUEUE_BYPASS_EN
    byp = keep & fifo_empty;
`else
    byp = 1'b0;
`endif

    head_valid = ~fifo_empty | byp;
    head       = fifo_empty ? resp_entry : fifo_head;

    pop       = (bus.ctr == CTR_ADV) & head_valid & ~redir;
    fifo_pop  = pop & ~fifo_empty;
    // A bypassed word consumed this cycle never enters the buffer.
    fifo_push = keep & ~(byp & pop);
  end

  // Next-state for PCs and request bookkeeping counters.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    last_npc_d    = last_npc_q;
    outstanding_d = outstanding_q + OW'(fire) - OW'(bus.imem_rvalid);
    discard_d     = discard_q;

    if (redir) begin
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      last_npc_d = redir_pc;
      // Everything still owed by memory after this cycle is stale.
      discard_d  = outstanding_q - OW'(bus.imem_rvalid);
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (keep) resp_pc_d = resp_pc_q + PC_STEP;
      if (pop)  last_npc_d = head.n_pc;
      if (bus.imem_rvalid && discard_q != '0) discard_d = discard_q - OW'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      last_npc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      assert (!(bus.imem_rvalid && outstanding_q == '0));
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      last_npc_q    <= last_npc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = head_valid;
  assign bus.busy      = ~head_valid;
  assign bus.isn       = head_valid ? head.isn : NOP_INSN;
  assign bus.n_pc      = head_valid ? head.n_pc : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a small in-order, fixed-latency memory model.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;

  fetch_queue_if bus();

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory model: a request accepted at an edge answers lat cycles later
  // (lat=1: valid in the cycle right after acceptance). Data = addr ^ data_mask.
  int          lat = 1;
  logic [31:0] data_mask = 32'h0;
  int          cyc;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_addr.delete();
      pend_due.delete();
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= 32'h0;
    end else begin
      if (bus.imem_req && bus.imem_ack) begin
        pend_addr.push_back(bus.imem_addr);
        pend_due.push_back(cyc + lat);
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= pend_addr[0] ^ data_mask;
        pend_addr.pop_front();
        pend_due.pop_front();
      end else begin
        bus.imem_rvalid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the bench just after the negedge where reset is released
  // with ack high and ctr=advance.
  task automatic do_reset(input int l, input logic [31:0] m);
    @(negedge clk);
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    bus.ctr = CTR_ADV;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    lat = l;
    data_mask = m;
    @(negedge clk);
    rst = 1'b1;
    bus.imem_ack = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    bus.ctr = CTR_STALL;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_ack = 1'b0;

    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd1);
    chk("rst_isn",       bus.isn,            32'h0);
    chk("rst_n_pc",      bus.n_pc,           32'h0);
    chk("rst_imem_req",  32'(bus.imem_req),  32'd1);
    chk("rst_imem_addr", bus.imem_addr,      32'h0);

`ifndef FETCH_QUEUE_BYPASS_EN
    // Streaming from reset with a one-cycle memory.
    do_reset(1, 32'h0);
    @(negedge clk); #1;
    chk("stream_busy_c1", 32'(bus.busy), 32'd1);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk); #1;
      chk("stream_isn",  bus.isn,  32'(4 * (k - 2)));
      chk("stream_n_pc", bus.n_pc, 32'(4 * (k - 2) + 4));
      if (k == 2) chk("stream_busy_c2", 32'(bus.busy), 32'd0);
    end
    bus.ctr = CTR_STALL;

    // Stall: buffer fills to DEPTH (16,20,24,28) and requests stop.
    for (int s = 0; s < 10; s++) begin
      @(negedge clk); #1;
      chk("stall_isn", bus.isn, 32'h10);
    end
    chk("stall_req",   32'(bus.imem_req),  32'd0);
    chk("stall_valid", 32'(bus.out_valid), 32'd1);
    bus.ctr = CTR_ADV;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk); #1;
      chk("resume_isn", bus.isn, 32'(16 + 4 * j));
      if (j == 1) chk("resume_req", 32'(bus.imem_req), 32'd1);
    end

    // Redirect with two requests in flight on a 3-cycle memory.
    do_reset(3, 32'h0);
    @(negedge clk);
    @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    #1;
    chk("redir_req_low", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    chk("redir_req",  32'(bus.imem_req), 32'd1);
    chk("redir_addr", bus.imem_addr,     32'h100);
    for (int c = 3; c <= 6; c++) begin
      chk("redir_drop_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk); #1;
    end
    chk("redir_isn",   bus.isn,  32'h100);
    chk("redir_n_pc",  bus.n_pc, 32'h104);
    @(negedge clk); #1;
    chk("redir_isn2",  bus.isn,  32'h104);

    // Redirect in the same cycle as a response.
    do_reset(1, 32'h0);
    @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    #1;
    chk("rvredir_req_low", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    chk("rvredir_req",   32'(bus.imem_req),  32'd1);
    chk("rvredir_addr",  bus.imem_addr,      32'h200);
    chk("rvredir_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk); #1;
    chk("rvredir_valid2", 32'(bus.out_valid), 32'd0);
    @(negedge clk); #1;
    chk("rvredir_isn",  bus.isn,  32'h200);
    chk("rvredir_n_pc", bus.n_pc, 32'h204);

    // Address wrap past the top of memory.
    @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFF8);
    chk("wrap_req0",  32'(bus.imem_req), 32'd1);
    @(negedge clk); #1;
    chk("wrap_addr1", bus.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap_addr2", bus.imem_addr, 32'h0);
    chk("wrap_isn0",  bus.isn,  32'hFFFF_FFF8);
    chk("wrap_npc0",  bus.n_pc, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap_isn1",  bus.isn,  32'hFFFF_FFFC);
    chk("wrap_npc1",  bus.n_pc, 32'h0);
    @(negedge clk); #1;
    chk("wrap_isn2",  bus.isn,  32'h0);
    chk("wrap_npc2",  bus.n_pc, 32'h4);

    // Flush without redirect refetches the unpopped head (address 0).
    bus.ctr = CTR_FLUSH;
    @(negedge clk);
    bus.ctr = CTR_ADV;
    #1;
    chk("flush_req",   32'(bus.imem_req),  32'd1);
    chk("flush_addr",  bus.imem_addr,      32'h0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk); #1;
    chk("flush_valid2", 32'(bus.out_valid), 32'd0);
    @(negedge clk); #1;
    chk("flush_isn",  bus.isn,  32'h0);
    chk("flush_n_pc", bus.n_pc, 32'h4);
`else
    // Bypass: first response is visible in the cycle it arrives and is
    // consumed without entering the buffer.
    do_reset(1, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    #1;
    chk("byp_valid", 32'(bus.out_valid), 32'd1);
    chk("byp_isn",   bus.isn,            32'hDEAD_BEEF);
    chk("byp_n_pc",  bus.n_pc,           32'h4);
    chk("byp_busy",  32'(bus.busy),      32'd0);
    @(negedge clk); #1;
    chk("byp_empty_valid", 32'(bus.out_valid), 32'd0);
    chk("byp_empty_isn",   bus.isn,            32'h0);
    chk("byp_req",         32'(bus.imem_req),  32'd1);
    chk("byp_addr",        bus.imem_addr,      32'h4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
